// File: rtl/cell_processor_pipe_pkg.sv
// Shared types and constants for the pipelined cell processor.
// Opcode encoding: everything above OP_AVG is illegal.
package cell_processor_pipe_pkg;

  localparam int CH_W_DEF   = 8;
  localparam int CH_NUM_DEF = 3;
  localparam int CELL_N_DEF = 3;
  localparam int OP_W_DEF   = 4;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADDI  = 4'd1,
    OP_SUB   = 4'd2,
    OP_SUBI  = 4'd3,
    OP_MULT  = 4'd4,
    OP_MULTI = 4'd5,
    OP_DIV2  = 4'd6,
    OP_INV   = 4'd7,
    OP_AND   = 4'd8,
    OP_OR    = 4'd9,
    OP_NOR   = 4'd10,
    OP_AVG   = 4'd11
  } opcodes_t;

  typedef logic [CH_W_DEF-1:0] chan_t;
  typedef logic [CH_NUM_DEF*CH_W_DEF-1:0] pixel_t;
  typedef logic [CELL_N_DEF*CELL_N_DEF*CH_NUM_DEF*CH_W_DEF-1:0] cell_t;

  function automatic int ctr_idx(input int n);
    return (n * n - 1) / 2;
  endfunction

  function automatic int avg_div(input int n);
    return n * n;
  endfunction

endpackage

// File: rtl/cell_processor_pipe_alu.sv
// One colour channel of stage 1: centre-pixel operation plus
// full-cell sum for averaging. Purely combinational.
module cell_channel_alu
  import cell_processor_pipe_pkg::*;
#(
  parameter int CH_W   = CH_W_DEF,
  parameter int CELL_N = CELL_N_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int SUM_W  = CH_W + $clog2(CELL_N * CELL_N)
) (
  input  logic [OP_W-1:0]             op,
  input  logic [CELL_N*CELL_N*CH_W-1:0] col_a,
  input  logic [CH_W-1:0]             b,
  input  logic [CH_W-1:0]             imm,
  output logic [2*CH_W-1:0]           wide,
  output logic [SUM_W-1:0]            sum
);

  localparam int N2  = CELL_N * CELL_N;
  localparam int CTR = ctr_idx(CELL_N);
  localparam int WW  = 2 * CH_W;

  opcodes_t        opc;
  logic [CH_W-1:0] a;
  logic [CH_W-1:0] opnd;
  logic [CH_W:0]   add_r;
  logic [CH_W:0]   sub_r;
  logic [WW-1:0]   prod;

  always_comb begin
    opc   = opcodes_t'(op);
    a     = col_a[CTR*CH_W +: CH_W];
    opnd  = (opc == OP_ADDI || opc == OP_SUBI || opc == OP_MULTI)
            ? imm : b;
    add_r = {1'b0, a} + {1'b0, opnd};
    sub_r = {1'b0, a} - {1'b0, opnd};
    prod  = WW'(a) * WW'(opnd);
    wide  = '0;
    unique case (opc)
      OP_ADD, OP_ADDI:   wide = {{(CH_W-1){1'b0}}, add_r};
      OP_SUB, OP_SUBI:   wide = {{(CH_W-1){1'b0}}, sub_r};
      OP_MULT, OP_MULTI: wide = prod;
      OP_DIV2:           wide = {{CH_W{1'b0}}, a >> 1};
      OP_INV:            wide = {{CH_W{1'b0}}, ~a};
      OP_AND:            wide = {{CH_W{1'b0}}, a & b};
      OP_OR:             wide = {{CH_W{1'b0}}, a | b};
      OP_NOR:            wide = {{CH_W{1'b0}}, ~(a | b)};
      default:           wide = '0;
    endcase
  end

  // Sum is kept wide enough that averaging never overflows.
  always_comb begin
    sum = '0;
    for (int k = 0; k < N2; k++)
      sum = sum + SUM_W'(col_a[k*CH_W +: CH_W]);
  end

endmodule

// File: rtl/cell_processor_pipe.sv
// Two-stage valid/ready cell processor emitting one centre pixel per beat.
// Define SATURATE_EN to clamp ADD/ADDI/SUB/SUBI instead of wrapping.
module cell_processor_pipe
  import cell_processor_pipe_pkg::*;
#(
  parameter int CH_W   = CH_W_DEF,
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int CELL_N = CELL_N_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [OP_W-1:0]                     in_op,
  input  logic [CELL_N*CELL_N*CH_NUM*CH_W-1:0] in_cell_a,
  input  logic [CELL_N*CELL_N*CH_NUM*CH_W-1:0] in_cell_b,
  input  logic [CH_W-1:0]                     in_imm,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CH_NUM*CH_W-1:0]              out_pixel,
  output logic                                out_err
);

  localparam int N2    = CELL_N * CELL_N;
  localparam int CTR   = ctr_idx(CELL_N);
  localparam int PIX_W = CH_NUM * CH_W;
  localparam int WW    = 2 * CH_W;
  localparam int SUM_W = CH_W + $clog2(N2);
  localparam logic [SUM_W-1:0] DIV    = SUM_W'(avg_div(CELL_N));
  localparam logic [OP_W-1:0]  OP_MAX = OP_W'(OP_AVG);

  logic                    s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]         s1_op_q, s1_op_d;
  logic                    s1_err_q, s1_err_d;
  logic [PIX_W-1:0]        s1_actr_q, s1_actr_d;
  logic [CH_NUM*WW-1:0]    s1_wide_q, s1_wide_d;
  logic [CH_NUM*SUM_W-1:0] s1_sum_q, s1_sum_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [PIX_W-1:0]        s2_pix_q, s2_pix_d;
  logic                    s2_err_q, s2_err_d;

  logic                    s1_adv;
  logic                    accept;
  logic [CH_NUM*WW-1:0]    alu_wide;
  logic [CH_NUM*SUM_W-1:0] alu_sum;
  logic [PIX_W-1:0]        res_pix;
  logic [WW-1:0]           w;
  logic [CH_W-1:0]         ch;
  logic                    unused_b;

  assign unused_b  = ^in_cell_b;
  assign s1_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !reset && (!s1_valid_q || s1_adv);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid_q;
  assign out_pixel = s2_pix_q;
  assign out_err   = s2_err_q;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [N2*CH_W-1:0] col;

    always_comb begin
      col = '0;
      for (int k = 0; k < N2; k++)
        col[k*CH_W +: CH_W] = in_cell_a[(k*CH_NUM+c)*CH_W +: CH_W];
    end

    cell_channel_alu #(
      .CH_W  (CH_W),
      .CELL_N(CELL_N),
      .OP_W  (OP_W),
      .SUM_W (SUM_W)
    ) u_alu (
      .op   (in_op),
      .col_a(col),
      .b    (in_cell_b[(CTR*CH_NUM+c)*CH_W +: CH_W]),
      .imm  (in_imm),
      .wide (alu_wide[c*WW +: WW]),
      .sum  (alu_sum[c*SUM_W +: SUM_W])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_err_d   = s1_err_q;
    s1_actr_d  = s1_actr_q;
    s1_wide_d  = s1_wide_q;
    s1_sum_d   = s1_sum_q;
    if (s1_adv)
      s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_err_d   = in_op > OP_MAX;
      s1_actr_d  = in_cell_a[CTR*PIX_W +: PIX_W];
      s1_wide_d  = alu_wide;
      s1_sum_d   = alu_sum;
    end
  end

  // Stage 2: narrow each channel back to CH_W bits.
  always_comb begin
    res_pix = '0;
    w       = '0;
    ch      = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      w  = s1_wide_q[c*WW +: WW];
      ch = w[CH_W-1:0];
      unique case (opcodes_t'(s1_op_q))
`ifdef SATURATE_EN
        OP_ADD, OP_ADDI: if (w[CH_W]) ch = '1;
        OP_SUB, OP_SUBI: if (w[CH_W]) ch = '0;
`endif
        OP_MULT, OP_MULTI: ch = w[WW-1:CH_W];
        OP_AVG: ch = CH_W'(s1_sum_q[c*SUM_W +: SUM_W] / DIV);
        default: ;
      endcase
      res_pix[c*CH_W +: CH_W] = ch;
    end
    if (s1_err_q)
      res_pix = s1_actr_q;
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_pix_d   = s2_pix_q;
    s2_err_d   = s2_err_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_pix_d = res_pix;
        s2_err_d = s1_err_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_err_q   <= 1'b0;
      s1_actr_q  <= '0;
      s1_wide_q  <= '0;
      s1_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_pix_q   <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_err_q   <= s1_err_d;
      s1_actr_q  <= s1_actr_d;
      s1_wide_q  <= s1_wide_d;
      s1_sum_q   <= s1_sum_d;
      s2_valid_q <= s2_valid_d;
      s2_pix_q   <= s2_pix_d;
      s2_err_q   <= s2_err_d;
    end
  end

endmodule
